// File: rtl/la_pkg.sv
// Shared types and constants for the la_capture logic analyser.
package la_pkg;

   // Capture sequencer states
   typedef enum logic [2:0] {
      IDLE,
      PRETRIG,
      WAIT_TRIG,
      POSTTRIG,
      DUMP
   } state_t;

   // Byte handshake phases used while dumping to uart_tx
   typedef enum logic [1:0] {
      PH_SEND,
      PH_WAIT_HI,
      PH_WAIT_LO
   } phase_t;

   // Marker byte sent ahead of every dump
   localparam logic [7:0] HEADER_BYTE = 8'hA5;

   // Number of UART bytes needed to carry one sample
   function automatic int bytesPerSample(input int channels);
      return channels / 8;
   endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample buffer with registered read (iCE40 BRAM friendly).
module la_sample_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     i_wrEn,
   input  logic [$clog2(DEPTH)-1:0] i_wrAddr,
   input  logic [WIDTH-1:0]         i_wrData,
   input  logic [$clog2(DEPTH)-1:0] i_rdAddr,
   output logic [WIDTH-1:0]         o_rdData
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdData;

   // Write port plus one-cycle-latency read port; contents are never reset
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
      r_rdData <= r_mem[i_rdAddr];
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/la_capture.sv
// Logic analyser core: samples probe pins into a circular buffer around a
// masked trigger, then streams header + buffer (oldest first) to uart_tx.
module la_capture
   import la_pkg::*;
#(
   parameter int CHANNELS = 8,
   parameter int DEPTH    = 256,
   parameter int PRE_TRIG = 64,
   parameter int DIV_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] probe,
   input  logic                arm,
   input  logic [DIV_W-1:0]    sample_div,
   input  logic [CHANNELS-1:0] trig_mask,
   input  logic [CHANNELS-1:0] trig_value,
   output logic [7:0]          tx_data,
   output logic                tx_data_valid,
   input  logic                transmitting,
   output logic                busy,
   output logic                triggered
);

   localparam int AW       = $clog2(DEPTH);
   localparam int CW       = AW + 1;
   localparam int BPS      = bytesPerSample(CHANNELS);
   localparam int BW       = (BPS > 1) ? $clog2(BPS) : 1;
   localparam int POST_LEN = DEPTH - PRE_TRIG;

   state_t r_state, w_stateNext;
   phase_t r_phase, w_phaseNext;

   logic [CHANNELS-1:0]     r_probeMeta, r_probeSync;
   logic                    r_armPrev;
   logic [DIV_W-1:0]        r_divCnt;
   logic [AW-1:0]           r_wrPtr, r_rdPtr;
   logic [CW-1:0]           r_sampleCnt, r_dumpCnt;
   logic                    r_triggered;
   logic                    r_headerPending;
   logic [BW-1:0]           r_byteIdx;
   logic [7:0]              r_txData;
   logic                    r_txValid;

   logic                    w_armRise, w_capturing, w_strobe, w_match;
   logic                    w_wrEn, w_trigHit, w_send, w_dumpEnter, w_allSent;
   logic [CHANNELS-1:0]     w_rdData;
   logic [BPS-1:0][7:0]     w_rdBytes;
   logic [7:0]              w_curByte;

   assign w_armRise   = arm & ~r_armPrev;
   assign w_capturing = (r_state == PRETRIG) || (r_state == WAIT_TRIG) || (r_state == POSTTRIG);
   assign w_strobe    = w_capturing && (r_divCnt == sample_div);
   assign w_match     = ((r_probeSync ^ trig_value) & trig_mask) == '0;
   assign w_allSent   = !r_headerPending && (r_dumpCnt == CW'(DEPTH));
   assign w_rdBytes   = w_rdData;
   assign w_curByte   = r_headerPending ? HEADER_BYTE : w_rdBytes[r_byteIdx];

   la_sample_ram #(
      .WIDTH (CHANNELS),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk      (clk),
      .i_wrEn   (w_wrEn),
      .i_wrAddr (r_wrPtr),
      .i_wrData (r_probeSync),
      .i_rdAddr (r_rdPtr),
      .o_rdData (w_rdData)
   );

   // State and dump-phase registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_phase <= PH_SEND;
      end else begin
         r_state <= w_stateNext;
         r_phase <= w_phaseNext;
      end
   end

   // Next-state logic plus the write/trigger/send strobes it implies
   always_comb begin
      w_stateNext = r_state;
      w_phaseNext = PH_SEND;
      w_wrEn      = 1'b0;
      w_trigHit   = 1'b0;
      w_send      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_armRise) begin
               w_stateNext = (PRE_TRIG == 0) ? WAIT_TRIG : PRETRIG;
            end
         end
         PRETRIG: begin
            if (w_strobe) begin
               w_wrEn = 1'b1;
               if (r_sampleCnt == CW'(PRE_TRIG - 1)) begin
                  w_stateNext = WAIT_TRIG;
               end
            end
         end
         WAIT_TRIG: begin
            if (w_strobe) begin
               w_wrEn = 1'b1;
               if (w_match) begin
                  w_trigHit   = 1'b1;
                  w_stateNext = (POST_LEN == 1) ? DUMP : POSTTRIG;
               end
            end
         end
         POSTTRIG: begin
            if (w_strobe) begin
               w_wrEn = 1'b1;
               if (r_sampleCnt == CW'(POST_LEN - 1)) begin
                  w_stateNext = DUMP;
               end
            end
         end
         DUMP: begin
            w_phaseNext = r_phase;
            case (r_phase)
               PH_SEND: begin
                  if (!transmitting) begin
                     w_send      = 1'b1;
                     w_phaseNext = PH_WAIT_HI;
                  end
               end
               PH_WAIT_HI: begin
                  if (transmitting) begin
                     w_phaseNext = PH_WAIT_LO;
                  end
               end
               PH_WAIT_LO: begin
                  if (!transmitting) begin
                     w_phaseNext = PH_SEND;
                     if (w_allSent) begin
                        w_stateNext = IDLE;
                     end
                  end
               end
               default: w_phaseNext = PH_SEND;
            endcase
         end
         default: w_stateNext = IDLE;
      endcase
   end

   assign w_dumpEnter = (r_state != DUMP) && (w_stateNext == DUMP);

   // Probe synchroniser and arm edge detector; arm history starts high so a
   // level held through reset does not look like a fresh edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_probeMeta <= '0;
         r_probeSync <= '0;
         r_armPrev   <= 1'b1;
      end else begin
         r_probeMeta <= probe;
         r_probeSync <= r_probeMeta;
         r_armPrev   <= arm;
      end
   end

   // Sample-rate divider, held at zero outside the capture states
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_divCnt <= '0;
      end else if (!w_capturing || w_strobe) begin
         r_divCnt <= '0;
      end else begin
         r_divCnt <= r_divCnt + DIV_W'(1);
      end
   end

   // Write pointer, pre/post sample counter and the triggered flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrPtr     <= '0;
         r_sampleCnt <= '0;
         r_triggered <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_wrPtr     <= '0;
            r_sampleCnt <= '0;
         end else if (w_wrEn) begin
            r_wrPtr <= r_wrPtr + AW'(1);
            if (w_trigHit) begin
               r_sampleCnt <= CW'(1);
            end else if (r_state != WAIT_TRIG) begin
               r_sampleCnt <= r_sampleCnt + CW'(1);
            end
         end
         if (w_stateNext == IDLE) begin
            r_triggered <= 1'b0;
         end else if (w_trigHit) begin
            r_triggered <= 1'b1;
         end
      end
   end

   // Dump sequencing: header first, then samples LSB byte first from the
   // oldest entry; the read address moves right after a sample's last byte
   // so the RAM output is settled long before the next send
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdPtr         <= '0;
         r_headerPending <= 1'b0;
         r_byteIdx       <= '0;
         r_dumpCnt       <= '0;
         r_txData        <= '0;
         r_txValid       <= 1'b0;
      end else begin
         r_txValid <= 1'b0;
         if (w_dumpEnter) begin
            r_rdPtr         <= r_wrPtr + AW'(1);
            r_headerPending <= 1'b1;
            r_byteIdx       <= '0;
            r_dumpCnt       <= '0;
         end else if (w_send) begin
            r_txValid <= 1'b1;
            r_txData  <= w_curByte;
            if (r_headerPending) begin
               r_headerPending <= 1'b0;
            end else if (r_byteIdx == BW'(BPS - 1)) begin
               r_byteIdx <= '0;
               r_rdPtr   <= r_rdPtr + AW'(1);
               r_dumpCnt <= r_dumpCnt + CW'(1);
            end else begin
               r_byteIdx <= r_byteIdx + BW'(1);
            end
         end
      end
   end

   assign tx_data       = r_txData;
   assign tx_data_valid = r_txValid;
   assign busy          = (r_state != IDLE);
   assign triggered     = r_triggered;

endmodule

// File: tb/tb_la_capture.sv
// Scoreboard bench for la_capture: a reference model predicts the dumped
// byte stream from the probe stream, a monitor checks every uart strobe.
module tb_la_capture;

   localparam int CH    = 16;
   localparam int DEPTH = 16;
   localparam int PRE   = 4;
   localparam int DIVW  = 16;
   localparam int N     = 1024;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [CH-1:0]   probe;
   logic            arm;
   logic [DIVW-1:0] sample_div;
   logic [CH-1:0]   trig_mask;
   logic [CH-1:0]   trig_value;
   logic [7:0]      tx_data;
   logic            tx_data_valid;
   logic            transmitting;
   logic            busy;
   logic            triggered;

   int              total = 0;
   int              bad = 0;
   int              pulseCount = 0;
   bit              uartRand = 1'b0;
   logic [7:0]      expQ [$];
   logic [CH-1:0]   pv [N];

   always #5 clk = ~clk;

   la_capture #(
      .CHANNELS (CH),
      .DEPTH    (DEPTH),
      .PRE_TRIG (PRE),
      .DIV_W    (DIVW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .probe         (probe),
      .arm           (arm),
      .sample_div    (sample_div),
      .trig_mask     (trig_mask),
      .trig_value    (trig_value),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .transmitting  (transmitting),
      .busy          (busy),
      .triggered     (triggered)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [CH-1:0] probeAt(input int m);
      if (m < 0) return pv[0];
      if (m >= N) return pv[N-1];
      return pv[m];
   endfunction

   // uart_tx stand-in: busy for a few cycles starting the cycle after a strobe
   initial begin
      int  uartCnt;
      bit  saw;
      uartCnt = 0;
      transmitting = 1'b0;
      forever begin
         @(negedge clk);
         saw = tx_data_valid;
         @(posedge clk);
         #1;
         if (saw) uartCnt = uartRand ? int'($urandom_range(1, 12)) : 10;
         else if (uartCnt > 0) uartCnt--;
         transmitting = (uartCnt != 0);
      end
   end

   // Monitor: every strobe must match the next predicted byte
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx_data_valid === 1'b1) begin
            pulseCount++;
            checkOutput("noPulseWhileBusy", transmitting, 1'b0);
            checkOutput("triggeredInDump", triggered, 1'b1);
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpectedByte actual=%0h required=none", tx_data);
            end else begin
               e = expQ.pop_front();
               checkOutput("dumpByte", tx_data, e);
            end
         end
      end
   end

   task automatic abortCapture(input string tag);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput({tag, " busy"}, busy, 1'b0);
      checkOutput({tag, " valid"}, tx_data_valid, 1'b0);
      checkOutput({tag, " triggered"}, triggered, 1'b0);
      checkOutput({tag, " txData"}, tx_data, 8'h00);
      expQ.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
   endtask

   // mode 0: counter probe, 1: random probe with guaranteed match, 2: constant 0x1234
   // abortMode 0: none, 1: reset during post-trigger, 2: reset during dump
   task automatic applyStimulus(input int div, input logic [CH-1:0] mask,
                                input logic [CH-1:0] valueIn, input int mode,
                                input int abortMode);
      logic [CH-1:0] value;
      logic [CH-1:0] s;
      int            tIdx;
      bit            done;
      bit            aborted;
      value = valueIn;
      for (int i = 0; i < N; i++) begin
         case (mode)
            0:       pv[i] = CH'(i);
            1:       pv[i] = CH'($urandom);
            default: pv[i] = 16'h1234;
         endcase
      end
      if (mode == 1) begin
         int k0;
         k0 = PRE + int'($urandom_range(10, 40));
         value = pv[div - 1 + k0 * (div + 1)];
      end
      // Reference model: sample k sees the probe (div-1)+k*(div+1) cycles after arm
      tIdx = -1;
      for (int k = PRE; k < 4000; k++) begin
         if (((probeAt(div - 1 + k * (div + 1)) ^ value) & mask) == '0) begin
            tIdx = k;
            break;
         end
      end
      if (tIdx < 0) begin
         total++;
         bad++;
         $display("[TB] FAIL modelTrigger actual=none required=found");
         return;
      end
      expQ.push_back(8'hA5);
      for (int j = 0; j < DEPTH; j++) begin
         s = probeAt(div - 1 + (tIdx - PRE + j) * (div + 1));
         expQ.push_back(s[7:0]);
         expQ.push_back(s[15:8]);
      end
      trig_mask  = mask;
      trig_value = value;
      sample_div = DIVW'(div);
      probe      = pv[0];
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      pulseCount = 0;
      arm   = 1'b1;
      probe = probeAt(0);
      done    = 1'b0;
      aborted = 1'b0;
      for (int m = 1; m <= 6000 && !done; m++) begin
         @(posedge clk);
         #1;
         probe = probeAt(m);
         if (m == 3) arm = 1'b0;
         else if (m == 6) arm = 1'b1;
         else if (m == 8) arm = 1'b0;
         if (abortMode == 1 && triggered && pulseCount == 0) begin
            abortCapture("abortPost");
            aborted = 1'b1;
            done = 1'b1;
         end else if (abortMode == 2 && pulseCount >= 5) begin
            abortCapture("abortDump");
            aborted = 1'b1;
            done = 1'b1;
         end else if (m > 2 && !busy) begin
            done = 1'b1;
         end
      end
      if (!done) begin
         total++;
         bad++;
         $display("[TB] FAIL captureTimeout actual=busy required=idle");
         abortCapture("recover");
      end else if (!aborted) begin
         checkOutput("pulseCount", pulseCount, 1 + 2 * DEPTH);
         checkOutput("queueDrained", expQ.size(), 0);
         checkOutput("triggeredCleared", triggered, 1'b0);
         repeat (3) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   // Global safety net against a stuck handshake
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [CH-1:0] rmask;
      rst_n      = 1'b0;
      arm        = 1'b1;
      probe      = '0;
      trig_mask  = '0;
      trig_value = '0;
      sample_div = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset txData", tx_data, 8'h00);
      checkOutput("reset valid", tx_data_valid, 1'b0);
      checkOutput("reset busy", busy, 1'b0);
      checkOutput("reset triggered", triggered, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      checkOutput("heldArmNoStart", busy, 1'b0);
      arm = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end

      $display("[TB] immediate trigger");
      applyStimulus(0, 16'h0000, 16'h0000, 0, 0);
      $display("[TB] pattern trigger");
      applyStimulus(0, 16'h000F, 16'h0005, 0, 0);
      $display("[TB] divider");
      applyStimulus(3, 16'h0000, 16'h0000, 0, 0);
      $display("[TB] constant probe width check");
      applyStimulus(1, 16'h0000, 16'h0000, 2, 0);

      uartRand = 1'b1;
      for (int r = 0; r < 3; r++) begin
         rmask = CH'($urandom) & CH'($urandom) & CH'($urandom);
         $display("[TB] random run %0d", r);
         applyStimulus(int'($urandom_range(0, 3)), rmask, 16'h0000, 1, 0);
      end

      $display("[TB] abort runs");
      applyStimulus(2, 16'h0000, 16'h0000, 0, 1);
      applyStimulus(0, 16'h0000, 16'h0000, 1, 2);
      applyStimulus(1, 16'h00F0, 16'h0000, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
